div_module: RTL and testbench

- Sequential unsigned restoring divider: the inverse datapath of the team's multiplier blocks.
- Takes a wide dividend and a narrow divisor and produces quotient and remainder, one quotient bit per clock.
- Uses a start/busy/done handshake.
- Used to recover an operand from a registered product, or for general ratio computation next to the multiplier stage.

---
 rtl/div_module_pkg.sv | 15 +
 rtl/div_step.sv | 25 ++
 rtl/div_module.sv | 95 +++++++++
 tb/tb_div_module.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_module_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the step-counter width derived from the dividend width.
package div_module_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } state_t;

  // Counter must reach a_w-1; keep at least one bit for degenerate widths.
  function automatic int cnt_width(input int a_w);
    return (a_w > 1) ? $clog2(a_w) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference only when it does not go negative.
module div_step #(
  parameter int B_W = 4
) (
  input  logic [B_W-1:0] rem_in,
  input  logic           bit_in,
  input  logic [B_W-1:0] divisor,
  output logic [B_W-1:0] rem_out,
  output logic           q_bit
);

  // The shifted remainder needs B_W+1 bits so the compare cannot wrap; the
  // result always drops back below the divisor and fits in B_W bits again.
  logic [B_W:0] shifted;

  // NOTE: every signal written here gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    shifted = {rem_in, bit_in};
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? B_W'(shifted - {1'b0, divisor}) : shifted[B_W-1:0];
  end

endmodule

// File: rtl/div_module.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with a
// start/busy/done handshake and registered quotient/remainder/div_zero.
module div_module
  import div_module_pkg::*;
#(
  parameter int A_W = 7,
  parameter int B_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [A_W-1:0] din_a,
  input  logic [B_W-1:0] din_b,
  output logic           busy,
  output logic           done,
  output logic [A_W-1:0] quotient,
  output logic [B_W-1:0] remainder,
  output logic           div_zero
);

  localparam int CNT_W = cnt_width(A_W);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
  // after A_W steps this register holds the quotient.
  logic [A_W-1:0]   dvd_sr;
  logic [B_W-1:0]   dsr;
  logic [B_W-1:0]   rem_r;

  logic [B_W-1:0]   rem_next;
  logic             q_bit;

  div_step #(.B_W(B_W)) u_step (
    .rem_in  (rem_r),
    .bit_in  (dvd_sr[A_W-1]),
    .divisor (dsr),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      dvd_sr    <= '0;
      dsr       <= '0;
      rem_r     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (din_b == '0) begin
              // Divide by zero completes at once without entering CALC.
              quotient  <= '1;
              remainder <= din_a[B_W-1:0];
              div_zero  <= 1'b1;
              done      <= 1'b1;
            end else begin
              dvd_sr <= din_a;
              dsr    <= din_b;
              rem_r  <= '0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          dvd_sr <= {dvd_sr[A_W-2:0], q_bit};
          rem_r  <= rem_next;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(A_W - 1)) begin
            quotient  <= {dvd_sr[A_W-2:0], q_bit};
            remainder <= rem_next;
            div_zero  <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_module.sv
// Self-checking bench for div_module: directed vector table, handshake and
// reset corner sequences, randomized ops against an arithmetic reference.
module tb_div_module;

  localparam int A_W = 7;
  localparam int B_W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [A_W-1:0] din_a;
  logic [B_W-1:0] din_b;
  logic           busy, done, div_zero;
  logic [A_W-1:0] quotient;
  logic [B_W-1:0] remainder;

  logic           start8;
  logic [7:0]     din_a8, din_b8;
  logic           busy8, done8, dz8;
  logic [7:0]     q8, r8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_module #(.A_W(A_W), .B_W(B_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .din_a     (din_a),
    .din_b     (din_b),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  div_module #(.A_W(8), .B_W(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start8),
    .din_a     (din_a8),
    .din_b     (din_b8),
    .busy      (busy8),
    .done      (done8),
    .quotient  (q8),
    .remainder (r8),
    .div_zero  (dz8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer division, with the documented divide-by-zero result.
  function automatic void ref_div(input int a, input int b, input int a_w, input int b_w,
                                  output int q, output int r, output int dz);
    if (b == 0) begin
      q  = (1 << a_w) - 1;
      r  = a % (1 << b_w);
      dz = 1;
    end else begin
      q  = a / b;
      r  = a % b;
      dz = 0;
    end
  endfunction

  // Issue one op on the 7/4 divider, wait for done (bounded), check all results.
  task automatic run_op(input string tag, input int a, input int b,
                        input int eq, input int er, input int edz);
    int lat;
    @(negedge clk);
    start = 1'b1; din_a = A_W'(a); din_b = B_W'(b);
    @(negedge clk);
    start = 1'b0; din_a = A_W'($urandom); din_b = B_W'($urandom);
    check({tag, " busy_after_start"}, busy, (b != 0));
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, (b == 0) ? 0 : A_W);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_zero"}, div_zero, edz);
    check({tag, " busy_at_done"}, busy, 0);
    @(negedge clk);
    check({tag, " done_one_cycle"}, done, 0);
  endtask

  task automatic run_op8(input string tag, input int a, input int b);
    int lat, eq, er, edz;
    ref_div(a, b, 8, 8, eq, er, edz);
    @(negedge clk);
    start8 = 1'b1; din_a8 = 8'(a); din_b8 = 8'(b);
    @(negedge clk);
    start8 = 1'b0; din_a8 = 8'($urandom); din_b8 = 8'($urandom);
    lat = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, (b == 0) ? 0 : 8);
    check({tag, " quotient"}, q8, eq);
    check({tag, " remainder"}, r8, er);
    check({tag, " div_zero"}, dz8, edz);
    @(negedge clk);
    check({tag, " done_one_cycle"}, done8, 0);
  endtask

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int dz;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int lat, pulses, eq, er, edz, a, b;

    vecs[0] = '{a: 100, b: 7,  q: 14,  r: 2,  dz: 0};
    vecs[1] = '{a: 127, b: 15, q: 8,   r: 7,  dz: 0};
    vecs[2] = '{a: 5,   b: 9,  q: 0,   r: 5,  dz: 0};
    vecs[3] = '{a: 0,   b: 3,  q: 0,   r: 0,  dz: 0};
    vecs[4] = '{a: 127, b: 1,  q: 127, r: 0,  dz: 0};
    vecs[5] = '{a: 93,  b: 0,  q: 127, r: 13, dz: 1};
    vecs[6] = '{a: 20,  b: 4,  q: 5,   r: 0,  dz: 0};

    rst = 1'b0; start = 1'b0; din_a = '0; din_b = '0;
    start8 = 1'b0; din_a8 = '0; din_b8 = '0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);
    check("reset div_zero", div_zero, 0);
    check("reset8 busy", busy8, 0);
    check("reset8 quotient", q8, 0);
    rst = 1'b0;

    foreach (vecs[i])
      run_op($sformatf("vec%0d %0d/%0d", i, vecs[i].a, vecs[i].b),
             vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz);

    // start held through busy with other operands: must be ignored
    @(negedge clk);
    start = 1'b1; din_a = 7'd100; din_b = 4'd7;
    @(negedge clk);
    din_a = 7'd50; din_b = 4'd3;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 6) start = 1'b0;
    end
    start = 1'b0;
    check("hold latency", lat, 7);
    check("hold quotient", quotient, 14);
    check("hold remainder", remainder, 2);
    repeat (3) @(negedge clk);
    check("hold no_queued busy", busy, 0);
    check("hold no_queued done", done, 0);
    check("hold result_kept", quotient, 14);

    // back-to-back: start in the done cycle is accepted
    @(negedge clk);
    start = 1'b1; din_a = 7'd100; din_b = 4'd7;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b first quotient", quotient, 14);
    start = 1'b1; din_a = 7'd45; din_b = 4'd6;
    @(negedge clk);
    start = 1'b0;
    check("b2b done_dropped", done, 0);
    check("b2b accepted busy", busy, 1);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("b2b latency", lat, 7);
    check("b2b quotient", quotient, 7);
    check("b2b remainder", remainder, 3);

    // reset three cycles into an op: immediate clear, no done pulse
    @(negedge clk);
    start = 1'b1; din_a = 7'd100; din_b = 4'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst quotient", quotient, 0);
    check("midrst remainder", remainder, 0);
    check("midrst div_zero", div_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("midrst no_done", pulses, 0);
    check("midrst idle", busy, 0);
    run_op("after_rst 100/7", 100, 7, 14, 2, 0);

    // wider instance
    run_op8("w8 255/16", 255, 16);
    run_op8("w8 200/0", 200, 0);
    for (int i = 0; i < 10; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      run_op8($sformatf("w8 rnd %0d/%0d", a, b), a, b);
    end

    // randomized ops on the default instance
    for (int i = 0; i < 30; i++) begin
      a = int'($urandom_range(0, 127));
      b = int'($urandom_range(0, 15));
      ref_div(a, b, A_W, B_W, eq, er, edz);
      run_op($sformatf("rnd %0d/%0d", a, b), a, b, eq, er, edz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
